// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, server state encoding and the padded-length helper
// used by the message server.
package sha256_pkg;

   localparam int         SHA_BLOCK_WORDS = 16;
   localparam logic [7:0] SHA_PAD_MARKER  = 8'h80;
   localparam int         SHA_LEN_WORDS   = 2;

   typedef enum logic {
      FILL  = 1'b0,
      SERVE = 1'b1
   } ServerState;

   // Smallest whole number of 512-bit blocks that holds message + marker + 64-bit length.
   function automatic logic [31:0] padded_total_words(input logic [31:0] nbytes);
      return (((nbytes + 32'd8) >> 6) + 32'd1) * 32'(SHA_BLOCK_WORDS);
   endfunction

endpackage

// File: rtl/sha256_pad_word.sv
// Combinational selector that turns a word address into the SHA-256 padded
// message word: stored data, marker, zero fill or the bit-length words.
module sha256_pad_word
   import sha256_pkg::*;
(
   input  logic [31:0] addr,
   input  logic [31:0] words,
   input  logic [31:0] total,
   input  logic [2:0]  last_bytes,
   input  logic [31:0] stored,
   input  logic [63:0] len_bits,
   output logic [31:0] padded
);

   // Length words take priority; the padding formula keeps them clear of data.
   always_comb begin
      padded = 32'h0000_0000;
      if (addr == total - 32'd1) begin
         padded = len_bits[31:0];
      end else if (addr == total - 32'(SHA_LEN_WORDS)) begin
         padded = len_bits[63:32];
      end else if (addr < words - 32'd1) begin
         padded = stored;
      end else if (addr == words - 32'd1) begin
         case (last_bytes)
            3'd1:    padded = {stored[31:24], SHA_PAD_MARKER, 16'h0000};
            3'd2:    padded = {stored[31:16], SHA_PAD_MARKER, 8'h00};
            3'd3:    padded = {stored[31:8], SHA_PAD_MARKER};
            default: padded = stored;
         endcase
      end else if ((addr == words) && (last_bytes == 3'd4)) begin
         padded = {SHA_PAD_MARKER, 24'h00_0000};
      end else begin
         padded = 32'h0000_0000;
      end
   end

endmodule

// File: rtl/sha256_msg_server.sv
// Memory-side responder for the SHA-256 chunk fetcher: buffers a raw host
// message and serves its padded form through a fixed-latency read pipeline.
module sha256_msg_server
   import sha256_pkg::*;
#(
   parameter int DEPTH_WORDS  = 64,
   parameter int READ_LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_vld,
   output logic        wr_rdy,
   input  logic [31:0] wr_data,
   input  logic        wr_last,
   input  logic [1:0]  wr_last_bytes,
   input  logic        msg_release,
   input  logic [31:0] mem_addr,
   output logic        mem_data_vld,
   output logic [31:0] mem_data,
   output logic        msg_ready,
   output logic [31:0] msg_total_words,
   output logic        overflow
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

   ServerState  state_r, state_nxt_s;
   logic [AW:0] cnt_r;
   logic [31:0] mem_buf_r [DEPTH_WORDS];
   logic [31:0] words_r, total_r;
   logic [2:0]  last_bytes_r;
   logic [63:0] len_bits_r;
   logic        wr_rdy_r, msg_ready_r, overflow_r;
   logic        accept_s, trunc_s, last_beat_s, flush_s, serve_s, addr_ok_s;
   logic [2:0]  beat_bytes_s;
   logic [31:0] nbytes_s, padded_s;
   logic        vld_pipe_r  [READ_LATENCY];
   logic [31:0] data_pipe_r [READ_LATENCY];

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_r <= FILL;
      else      state_r <= state_nxt_s;
   end

   // Next-state decode.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         FILL:    if (accept_s && last_beat_s) state_nxt_s = SERVE; else state_nxt_s = FILL;
         SERVE:   if (msg_release) state_nxt_s = FILL; else state_nxt_s = SERVE;
         default: state_nxt_s = FILL;
      endcase
   end

   // Per-state strobes plus the byte count a closing beat would latch.
   always_comb begin
      accept_s = 1'b0;
      serve_s  = 1'b0;
      flush_s  = 1'b0;
      case (state_r)
         FILL:    accept_s = wr_vld && wr_rdy_r;
         SERVE:   begin serve_s = !msg_release; flush_s = msg_release; end
         default: accept_s = 1'b0;
      endcase
      // A full buffer closes the message even without wr_last.
      trunc_s     = (32'(cnt_r) == 32'(DEPTH_WORDS - 1)) && !wr_last;
      last_beat_s = wr_last || trunc_s;
      if (trunc_s || (wr_last_bytes == 2'd0)) beat_bytes_s = 3'd4;
      else                                    beat_bytes_s = {1'b0, wr_last_bytes};
      nbytes_s  = (32'(cnt_r) << 2) + 32'(beat_bytes_s);
      addr_ok_s = serve_s && (mem_addr < total_r);
   end

   // Host-ready flag tracks the upcoming state so it drops with the closing beat.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) wr_rdy_r <= 1'b0;
      else      wr_rdy_r <= (state_nxt_s == FILL);
   end

   // Message bookkeeping latched by the closing beat, cleared by release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_r        <= '0;
         words_r      <= 32'h0;
         total_r      <= 32'h0;
         last_bytes_r <= 3'd0;
         len_bits_r   <= 64'h0;
         msg_ready_r  <= 1'b0;
         overflow_r   <= 1'b0;
      end else if (flush_s) begin
         cnt_r       <= '0;
         total_r     <= 32'h0;
         msg_ready_r <= 1'b0;
         overflow_r  <= 1'b0;
      end else if (accept_s) begin
         cnt_r <= cnt_r + CNT_ONE;
         if (last_beat_s) begin
            words_r      <= (nbytes_s + 32'd3) >> 2;
            total_r      <= padded_total_words(nbytes_s);
            last_bytes_r <= beat_bytes_s;
            len_bits_r   <= {29'd0, nbytes_s, 3'b000};
            msg_ready_r  <= 1'b1;
            overflow_r   <= trunc_s;
         end
      end
   end

   // Message storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (accept_s) mem_buf_r[cnt_r[AW-1:0]] <= wr_data;
   end

   sha256_pad_word u_pad (
      .addr       (mem_addr),
      .words      (words_r),
      .total      (total_r),
      .last_bytes (last_bytes_r),
      .stored     (mem_buf_r[mem_addr[AW-1:0]]),
      .len_bits   (len_bits_r),
      .padded     (padded_s)
   );

   // Read pipeline; release wipes every in-flight response.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < READ_LATENCY; i++) begin
            vld_pipe_r[i]  <= 1'b0;
            data_pipe_r[i] <= 32'h0;
         end
      end else if (flush_s) begin
         for (int i = 0; i < READ_LATENCY; i++) begin
            vld_pipe_r[i]  <= 1'b0;
            data_pipe_r[i] <= 32'h0;
         end
      end else begin
         vld_pipe_r[0]  <= addr_ok_s;
         data_pipe_r[0] <= addr_ok_s ? padded_s : 32'h0;
         for (int i = 1; i < READ_LATENCY; i++) begin
            vld_pipe_r[i]  <= vld_pipe_r[i-1];
            data_pipe_r[i] <= data_pipe_r[i-1];
         end
      end
   end

   assign wr_rdy          = wr_rdy_r;
   assign msg_ready       = msg_ready_r;
   assign msg_total_words = total_r;
   assign overflow        = overflow_r;
   assign mem_data_vld    = vld_pipe_r[READ_LATENCY-1];
   assign mem_data        = data_pipe_r[READ_LATENCY-1];

endmodule

// File: tb/tb_sha256_msg_server.sv
// Randomized bench for sha256_msg_server against a byte-level padding model.
module tb_sha256_msg_server;

   localparam int LAT   = 2;
   localparam int S_LAT = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, wr_vld, wr_rdy, wr_last, msg_release, mem_data_vld, msg_ready, overflow;
   logic [31:0] wr_data, mem_addr, mem_data, msg_total_words;
   logic [1:0]  wr_last_bytes;
   logic        s_wr_vld, s_wr_rdy, s_wr_last, s_release, s_vld, s_ready, s_overflow;
   logic [31:0] s_wr_data, s_mem_addr, s_data, s_total;
   logic [1:0]  s_wr_last_bytes;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0]  msg_q[$];
   logic [31:0] rd_q[$];

   sha256_msg_server #(.DEPTH_WORDS(64), .READ_LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_data(wr_data),
      .wr_last(wr_last), .wr_last_bytes(wr_last_bytes), .msg_release(msg_release),
      .mem_addr(mem_addr), .mem_data_vld(mem_data_vld), .mem_data(mem_data),
      .msg_ready(msg_ready), .msg_total_words(msg_total_words), .overflow(overflow));

   sha256_msg_server #(.DEPTH_WORDS(4), .READ_LATENCY(S_LAT)) dut_small (
      .clk(clk), .rst(rst), .wr_vld(s_wr_vld), .wr_rdy(s_wr_rdy), .wr_data(s_wr_data),
      .wr_last(s_wr_last), .wr_last_bytes(s_wr_last_bytes), .msg_release(s_release),
      .mem_addr(s_mem_addr), .mem_data_vld(s_vld), .mem_data(s_data),
      .msg_ready(s_ready), .msg_total_words(s_total), .overflow(s_overflow));

   // Padded length in words: message + 0x80 + 8 length bytes, rounded up to 64-byte blocks.
   function automatic int model_total();
      return ((msg_q.size() + 9 + 63) / 64) * 16;
   endfunction

   function automatic logic [7:0] pad_byte(int i);
      int n = msg_q.size();
      int len = model_total() * 4;
      logic [63:0] bits = 64'(n) * 64'd8;
      if (i < n)              return msg_q[i];
      else if (i == n)        return 8'h80;
      else if (i >= len - 8)  return bits[(8*(len-1-i)) +: 8];
      else                    return 8'h00;
   endfunction

   function automatic logic [31:0] model_word(int a);
      return {pad_byte(4*a), pad_byte(4*a+1), pad_byte(4*a+2), pad_byte(4*a+3)};
   endfunction

   task automatic fill_random(input int n);
      msg_q.delete();
      for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
   endtask

   task automatic load_msg(input bit trunc);
      int n = msg_q.size();
      int words = (n + 3) / 4;
      int guard;
      logic [31:0] w;
      for (int k = 0; k < words; k++) begin
         for (int b = 0; b < 4; b++)
            w[31-8*b -: 8] = (4*k + b < n) ? msg_q[4*k+b] : 8'($urandom);
         wr_vld = 1'b1; wr_data = w;
         wr_last = !trunc && (k == words - 1);
         wr_last_bytes = 2'(n % 4);
         guard = 0;
         while (wr_rdy !== 1'b1 && guard < 20) begin @(posedge clk); #1; guard++; end
         n_checks++;
         if (guard >= 20) begin n_fail++; $display("FAIL load_rdy: wr_rdy=%b want 1 (beat %0d)", wr_rdy, k); end
         @(posedge clk); #1;
      end
      wr_vld = 1'b0; wr_last = 1'b0;
      n_checks++;
      if (msg_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready: got %b want 1", msg_ready); end
      n_checks++;
      if (wr_rdy !== 1'b0) begin n_fail++; $display("FAIL load_wr_rdy: got %b want 0", wr_rdy); end
      n_checks++;
      if (msg_total_words !== 32'(model_total())) begin
         n_fail++; $display("FAIL load_total: got %0d want %0d", msg_total_words, model_total());
      end
      n_checks++;
      if (overflow !== trunc) begin n_fail++; $display("FAIL load_overflow: got %b want %b", overflow, trunc); end
   endtask

   // Streams rd_q one address per cycle and checks each slot exactly LAT cycles later.
   task automatic run_reads(input string name);
      logic        exp_v_q[$];
      logic [31:0] exp_d_q[$];
      logic [31:0] addr_q[$];
      logic [31:0] a, ea;
      logic        ev;
      logic [31:0] ed;
      int n = rd_q.size();
      for (int i = 0; i < n + LAT; i++) begin
         if (i >= LAT) begin
            ev = exp_v_q.pop_front(); ed = exp_d_q.pop_front(); ea = addr_q.pop_front();
            n_checks++;
            if (mem_data_vld !== ev || mem_data !== ed) begin
               n_fail++;
               $display("FAIL %s A%0d: got vld=%b data=%h want vld=%b data=%h", name, ea, mem_data_vld, mem_data, ev, ed);
            end
         end
         a = (i < n) ? rd_q[i] : 32'hFFFF_FFFF;
         mem_addr = a;
         addr_q.push_back(a);
         exp_v_q.push_back(a < 32'(model_total()));
         exp_d_q.push_back((a < 32'(model_total())) ? model_word(int'(a)) : 32'h0);
         @(posedge clk); #1;
      end
      rd_q.delete();
   endtask

   task automatic do_release();
      msg_release = 1'b1;
      @(posedge clk); #1;
      msg_release = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #12;
      n_checks++;
      if ({wr_rdy, mem_data_vld, msg_ready, overflow} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_flags: got %b want 0000", {wr_rdy, mem_data_vld, msg_ready, overflow});
      end
      n_checks++;
      if (mem_data !== 32'h0 || msg_total_words !== 32'h0) begin
         n_fail++; $display("FAIL reset_data: got data=%h total=%h want 0", mem_data, msg_total_words);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (wr_rdy !== 1'b1 || s_wr_rdy !== 1'b1 || msg_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_exit: got rdy=%b s_rdy=%b ready=%b want 1 1 0", wr_rdy, s_wr_rdy, msg_ready);
      end
   endtask

   task automatic test_abc();
      msg_q = '{8'h61, 8'h62, 8'h63};
      load_msg(1'b0);
      for (int a = 0; a <= 16; a++) rd_q.push_back(32'(a));
      run_reads("abc");
      do_release();
   endtask

   task automatic test_boundary_lengths();
      int lens[2] = '{55, 56};
      for (int k = 0; k < 2; k++) begin
         fill_random(lens[k]);
         load_msg(1'b0);
         for (int a = 0; a <= model_total(); a++) rd_q.push_back(32'(a));
         run_reads($sformatf("len%0d", lens[k]));
         do_release();
      end
   endtask

   task automatic test_overflow();
      logic [31:0] sw[4];
      logic [31:0] sa[9] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd14, 32'd15, 32'd16};
      logic [31:0] sd[9];
      logic        sv[9];
      for (int k = 0; k < 4; k++) sw[k] = $urandom;
      sd = '{sw[0], sw[1], sw[2], sw[3], 32'h8000_0000, 32'h0, 32'h0, 32'h0000_0080, 32'h0};
      sv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int k = 0; k < 4; k++) begin
         s_wr_vld = 1'b1; s_wr_data = sw[k]; s_wr_last = 1'b0; s_wr_last_bytes = 2'd1;
         @(posedge clk); #1;
      end
      s_wr_vld = 1'b0;
      n_checks++;
      if (s_overflow !== 1'b1 || s_ready !== 1'b1 || s_wr_rdy !== 1'b0) begin
         n_fail++; $display("FAIL ovf_flags: got ovf=%b ready=%b rdy=%b want 1 1 0", s_overflow, s_ready, s_wr_rdy);
      end
      n_checks++;
      if (s_total !== 32'd16) begin n_fail++; $display("FAIL ovf_total: got %0d want 16", s_total); end
      for (int i = 0; i < 9 + S_LAT; i++) begin
         if (i >= S_LAT) begin
            n_checks++;
            if (s_vld !== sv[i-S_LAT] || s_data !== sd[i-S_LAT]) begin
               n_fail++;
               $display("FAIL ovf_read A%0d: got vld=%b data=%h want vld=%b data=%h",
                        sa[i-S_LAT], s_vld, s_data, sv[i-S_LAT], sd[i-S_LAT]);
            end
         end
         s_mem_addr = (i < 9) ? sa[i] : 32'hFFFF_FFFF;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_release();
      msg_q = '{8'h61, 8'h62, 8'h63};
      load_msg(1'b0);
      for (int i = 0; i < 4; i++) begin mem_addr = 32'(i); @(posedge clk); #1; end
      n_checks++;
      if (mem_data_vld !== 1'b1) begin n_fail++; $display("FAIL rel_stream: vld=%b want 1", mem_data_vld); end
      mem_addr = 32'd4;
      do_release();
      n_checks++;
      if ({mem_data_vld, msg_ready, overflow, wr_rdy} !== 4'b0001 || msg_total_words !== 32'h0 || mem_data !== 32'h0) begin
         n_fail++;
         $display("FAIL rel_state: got vld=%b ready=%b ovf=%b rdy=%b total=%0d data=%h want 0 0 0 1 0 0",
                  mem_data_vld, msg_ready, overflow, wr_rdy, msg_total_words, mem_data);
      end
      for (int i = 0; i < LAT + 2; i++) begin
         mem_addr = 32'(i);
         @(posedge clk); #1;
         n_checks++;
         if (mem_data_vld !== 1'b0 || mem_data !== 32'h0) begin
            n_fail++; $display("FAIL rel_quiet: got vld=%b data=%h want 0 0", mem_data_vld, mem_data);
         end
      end
      load_msg(1'b0);
      for (int a = 0; a <= 16; a++) rd_q.push_back(32'(a));
      run_reads("rel_abc");
      do_release();
   endtask

   task automatic test_random();
      int  n;
      bit  trunc;
      for (int k = 0; k < 6; k++) begin
         trunc = (k == 2);
         n = trunc ? 256 : int'($urandom_range(1, 255));
         fill_random(n);
         load_msg(trunc);
         for (int a = 0; a < model_total() + 2; a++) rd_q.push_back(32'(a));
         for (int j = 0; j < 12; j++) rd_q.push_back(32'($urandom_range(0, model_total() + 3)));
         run_reads($sformatf("rand%0d_n%0d", k, n));
         do_release();
      end
   endtask

   task automatic test_async_reset();
      fill_random(20);
      for (int k = 0; k < 2; k++) begin
         wr_vld = 1'b1; wr_data = $urandom; wr_last = 1'b0;
         @(posedge clk); #1;
      end
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if ({wr_rdy, msg_ready, mem_data_vld, overflow} !== 4'b0000 || msg_total_words !== 32'h0) begin
         n_fail++; $display("FAIL arst_load: got rdy=%b ready=%b vld=%b ovf=%b total=%0d want all 0",
                            wr_rdy, msg_ready, mem_data_vld, overflow, msg_total_words);
      end
      wr_vld = 1'b0;
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (wr_rdy !== 1'b1 || msg_ready !== 1'b0) begin
         n_fail++; $display("FAIL arst_load_exit: got rdy=%b ready=%b want 1 0", wr_rdy, msg_ready);
      end
      fill_random(30);
      load_msg(1'b0);
      for (int i = 0; i < LAT + 1; i++) begin mem_addr = 32'(i); @(posedge clk); #1; end
      n_checks++;
      if (mem_data_vld !== 1'b1) begin n_fail++; $display("FAIL arst_serve_pre: vld=%b want 1", mem_data_vld); end
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if ({mem_data_vld, msg_ready, wr_rdy, s_vld, s_ready} !== 5'b00000 || mem_data !== 32'h0 || msg_total_words !== 32'h0) begin
         n_fail++; $display("FAIL arst_serve: got vld=%b ready=%b rdy=%b s_vld=%b s_ready=%b data=%h total=%0d want all 0",
                            mem_data_vld, msg_ready, wr_rdy, s_vld, s_ready, mem_data, msg_total_words);
      end
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (wr_rdy !== 1'b1 || msg_ready !== 1'b0 || mem_data_vld !== 1'b0) begin
         n_fail++; $display("FAIL arst_serve_exit: got rdy=%b ready=%b vld=%b want 1 0 0", wr_rdy, msg_ready, mem_data_vld);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; wr_vld = 1'b0; wr_data = 32'h0; wr_last = 1'b0; wr_last_bytes = 2'd0;
      msg_release = 1'b0; mem_addr = 32'h0;
      s_wr_vld = 1'b0; s_wr_data = 32'h0; s_wr_last = 1'b0; s_wr_last_bytes = 2'd0;
      s_release = 1'b0; s_mem_addr = 32'h0;
      test_reset();
      test_abc();
      test_boundary_lengths();
      test_overflow();
      test_release();
      test_random();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sha256_msg_server.md
Name: sha256_msg_server

Overview:
- Memory-side responder for the SHA-256 chunk fetch interface: it answers the `mem_addr` / `mem_data_vld` / `mem_data` reads issued by the chunk fetcher.
- A host loads a raw message word by word. The block then serves the SHA-256-padded message on the fly: message words, the 0x80 marker, zero fill and the 64-bit bit length.
- It sits between the host loader and `sha256`, replacing a plain RAM.

Parameters:
- DEPTH_WORDS, 64: maximum raw message words stored (power of 2, ≥2).
- READ_LATENCY, 2: cycles from `mem_addr` sample to the matching response (legal 1..4).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- wr_vld  in  1  host message word valid.
- wr_rdy  out  1  host word accepted when `wr_vld && wr_rdy`.
- wr_data  in  32  message word, big-endian (byte0 = [31:24]).
- wr_last  in  1  final message word.
- wr_last_bytes  in  2  valid bytes in the final word; 0 means 4.
- release  in  1  discard the current message and return to FILL.
- mem_addr  in  32  word address from the chunk fetcher.
- mem_data_vld  out  1  response valid.
- mem_data  out  32  response word.
- msg_ready  out  1  padded message is available.
- msg_total_words  out  32  padded length in words (multiple of 16).
- overflow  out  1  message truncated at DEPTH_WORDS.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to FILL and the word count clears.
  - The read pipeline is flushed.
  - `wr_rdy`, `mem_data_vld`, `mem_data`, `msg_ready`, `msg_total_words` and `overflow` are all 0.
- FILL state:
  - `wr_rdy` = 1 from the first cycle after reset deassertion.
  - Each accepted beat writes `wr_data` to `buf[cnt]` and increments `cnt`.
  - A beat with `wr_last`=1 latches `nbytes = (cnt_before)*4 + (wr_last_bytes==0 ? 4 : wr_last_bytes)`. The state then goes to SERVE on the next edge.
  - A beat accepted at index DEPTH_WORDS-1 is treated as last with 4 valid bytes, even if `wr_last`=0, and sets `overflow`.
  - `release` is ignored in FILL.
- Transition to SERVE:
  - `len_bits = nbytes*8`, held as 64 bits.
  - `msg_total_words = (floor((nbytes+8)/64)+1)*16`.
  - `msg_ready` = 1 and `wr_rdy` = 0.
- SERVE state:
  - `mem_addr` is sampled every cycle.
  - The response appears exactly READ_LATENCY cycles later, fully pipelined with one response per cycle and no backpressure.
- SERVE response for address A, with T = `msg_total_words` and W = `ceil(nbytes/4)`:
  - A < W-1: `buf[A]`.
  - A == W-1: valid bytes from `buf[A]`. If fewer than 4 bytes are valid, the first invalid byte is 0x80 and the rest are 0x00. If 4 bytes are valid, the full word is returned.
  - A == W and the last word was full: 0x80000000. This rule does not apply when A == T-2 or T-1, because the padding formula guarantees room.
  - Otherwise, W ≤ A < T-2: 0x00000000.
  - A == T-2: `len_bits[63:32]`.
  - A == T-1: `len_bits[31:0]`.
  - A ≥ T: `mem_data_vld` = 0, `mem_data` = 0.
- Invalid slots: `mem_data_vld` = 0 forces `mem_data` = 0. Addresses sampled in FILL produce invalid slots.
- release:
  - `release` = 1 in SERVE returns the state to FILL on the next edge.
  - It clears `cnt`, `msg_ready`, `overflow` and `msg_total_words`.
  - Responses already in the pipeline are suppressed (`vld` = 0).
- Reset mid-operation: asynchronous return to the reset state; buffer contents become don't-care.

Decomposition:
- sha256_pkg additions: `SHA_BLOCK_WORDS`=16, `SHA_PAD_MARKER`=8'h80, `SHA_LEN_WORDS`=2, and a typedef `ServerState` {FILL, SERVE}.
- One sub-module, `sha256_pad_word`: combinational. Inputs are A, W, T, last-valid-bytes, the stored word and `len_bits`; output is the padded word. It is instantiated in the pipeline's first stage, which is followed by READ_LATENCY-1 register stages.

Test Plan:
- "abc" test:
  - Stimulus: write 0x61626300 with `wr_last`=1, `wr_last_bytes`=3, then read addresses 0..16.
  - Response: `msg_total_words`=16.
  - A0 returns 0x61626380 and A1..A14 return 0.
  - A15 returns 0x00000018; A16 returns `vld`=0.
  - Each response arrives exactly READ_LATENCY cycles after its address.
- 55-byte test:
  - Stimulus: 14 words, last `wr_last_bytes`=3.
  - Response: T=16, A13 low byte = 0x80, A14 = 0, A15 = 0x000001B8.
- 56-byte test:
  - Stimulus: 14 full words.
  - Response: T=32, A14 = 0x80000000, A15..A29 = 0, A30 = 0, A31 = 0x000001C0.
- Overflow test:
  - Stimulus: DEPTH_WORDS=4, write 4 beats with no `wr_last`.
  - Response: `overflow`=1, `nbytes`=16, T=16, A4 = 0x80000000, A15 = 0x00000080.
- Release flush test:
  - Stimulus: assert `release` while reads are streaming.
  - Response: no `vld` after the release edge; `wr_rdy`=1 next cycle; reload "abc" and repeat the "abc" results.
- Asynchronous reset test:
  - Stimulus: drop `rst` mid-load and mid-serve, with no clock edge.
  - Response: outputs go to 0 immediately; after release, `wr_rdy`=1 and `msg_ready`=0.
